load_store_unit: RTL and testbench

- Multi-cycle load/store unit between the datapath and the word-addressed data memory.
- Accepts byte-addressed byte, halfword and word requests through a valid/ready handshake.
- Converts each byte address to a word index and drives the memory port.
- Sub-word stores use read-modify-write; loads are returned sign- or zero-extended; misaligned and out-of-range requests are rejected without touching memory.

---
 rtl/load_store_unit.sv | 186 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle byte/half/word load-store engine between the
// datapath and a word-addressed, combinationally read data memory.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   req_valid/ready    request handshake (ready only in IDLE, not in reset)
//   req_write          1 = store, 0 = load
//   req_size           00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned       load zero-extend (1) / sign-extend (0)
//   req_addr           byte address
//   req_wdata          right-aligned store data
//   resp_valid         one-cycle completion pulse
//   resp_rdata         extended load data (0 for stores and errors)
//   resp_error         misaligned, illegal size or out-of-range request
//   mem_address        word index driven in ACCESS/WRITE, else 0
//   mem_write_data     word to write
//   mem_write          write enable (forced low while reset is high)
//   mem_read_data      combinational read data for mem_address
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned IDX_W = 30;
  localparam logic [IDX_W-1:0] MEM_LIMIT = IDX_W'(MEM_WORDS);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_e;

  state_e      state_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic        write_q;
  logic        unsigned_q;
  logic [15:0] wdata_q;   // only sub-word stores need the latched data

  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_error_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_write_data_q;
  logic        mem_write_q;

  logic        accept;
  logic        req_err;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;
  logic [31:0] merge_word;

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // Reject illegal size, misalignment and indices past the end of memory
  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11)                                req_err = 1'b1;
    if (req_size == SIZE_HALF && req_addr[0] != 1'b0)     req_err = 1'b1;
    if (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)  req_err = 1'b1;
    if (req_addr[31:2] >= MEM_LIMIT)                      req_err = 1'b1;
  end

  // Little-endian lane extraction and extension for loads
  always_comb begin
    load_byte = mem_read_data[{lane_q, 3'b000} +: 8];
    load_half = lane_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (size_q)
      SIZE_BYTE: load_ext = {{24{~unsigned_q & load_byte[7]}}, load_byte};
      SIZE_HALF: load_ext = {{16{~unsigned_q & load_half[15]}}, load_half};
      default:   load_ext = mem_read_data;
    endcase
  end

  // Read-modify-write merge for sub-word stores
  always_comb begin
    merge_word = mem_read_data;
    if (size_q == SIZE_BYTE) begin
      merge_word[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else if (lane_q[1]) begin
      merge_word[31:16] = wdata_q;
    end else begin
      merge_word[15:0] = wdata_q;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      size_q           <= 2'b00;
      lane_q           <= 2'b00;
      write_q          <= 1'b0;
      unsigned_q       <= 1'b0;
      wdata_q          <= 16'h0;
      resp_valid_q     <= 1'b0;
      resp_rdata_q     <= 32'h0;
      resp_error_q     <= 1'b0;
      mem_address_q    <= 32'h0;
      mem_write_data_q <= 32'h0;
      mem_write_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            size_q     <= req_size;
            lane_q     <= req_addr[1:0];
            write_q    <= req_write;
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata[15:0];
            if (req_err) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              resp_rdata_q <= 32'h0;
            end else begin
              state_q       <= ACCESS;
              mem_address_q <= {2'b00, req_addr[31:2]};
              // Word stores write directly during ACCESS
              if (req_write && req_size == SIZE_WORD) begin
                mem_write_q      <= 1'b1;
                mem_write_data_q <= req_wdata;
              end
            end
          end
        end
        ACCESS: begin
          if (write_q && size_q != SIZE_WORD) begin
            state_q          <= WRITE;
            mem_write_q      <= 1'b1;
            mem_write_data_q <= merge_word;
          end else begin
            state_q          <= RESP;
            resp_valid_q     <= 1'b1;
            resp_rdata_q     <= write_q ? 32'h0 : load_ext;
            mem_write_q      <= 1'b0;
            mem_write_data_q <= 32'h0;
            mem_address_q    <= 32'h0;
          end
        end
        WRITE: begin
          state_q          <= RESP;
          resp_valid_q     <= 1'b1;
          resp_rdata_q     <= 32'h0;
          mem_write_q      <= 1'b0;
          mem_write_data_q <= 32'h0;
          mem_address_q    <= 32'h0;
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= 32'h0;
          resp_error_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_error     = resp_error_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  // No write may reach memory in a reset cycle
  assign mem_write      = mem_write_q && !reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 256-word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:255];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(256)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_error    (resp_error),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_write     (mem_write),
    .mem_read_data (mem_read_data)
  );

  assign mem_read_data = mem[mem_address[7:0]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_address[7:0]] <= mem_write_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issue one request and observe it (bounded) until its response
  task automatic run(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                     input int exp_wr_k, input logic [31:0] exp_wr_addr);
    logic [31:0] rdata;
    logic        err;
    logic [31:0] wr_addr;
    int lat, wr_k, wr_cnt;
    rdata = 32'hx; err = 1'bx; wr_addr = 32'h0;
    lat = 0; wr_k = 0; wr_cnt = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    check({tag, "/ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_write) begin
        wr_cnt++;
        if (wr_k == 0) begin
          wr_k = k;
          wr_addr = mem_address;
        end
      end
      if (resp_valid) begin
        lat = k; rdata = resp_rdata; err = resp_error;
        break;
      end
    end
    check({tag, "/lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "/rdata"}, rdata, exp_rdata);
    check({tag, "/err"}, 32'(err), 32'(exp_err));
    check({tag, "/wr_cycle"}, 32'(wr_k), 32'(exp_wr_k));
    check({tag, "/wr_cnt"}, 32'(wr_cnt), (exp_wr_k != 0) ? 32'd1 : 32'd0);
    if (exp_wr_k != 0) check({tag, "/wr_addr"}, wr_addr, exp_wr_addr);
    @(negedge clk);
    check({tag, "/single_pulse"}, 32'(resp_valid), 32'd0);
  endtask

  // Back-to-back stimulus with req_valid held high
  logic        b_wr   [3] = '{1'b0, 1'b1, 1'b0};
  logic [1:0]  b_sz   [3] = '{2'b10, 2'b00, 2'b10};
  logic [31:0] b_addr [3] = '{32'h20, 32'h21, 32'h20};
  logic [31:0] b_wd   [3] = '{32'h0, 32'h55, 32'h0};
  logic [31:0] b_exp  [3] = '{32'hDEADBEEF, 32'h0, 32'hDEAD55EF};

  initial begin
    int idx, nresp, busy, extra;
    logic rdy;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst/ready", 32'(req_ready), 32'd0);
    check("rst/resp_valid", 32'(resp_valid), 32'd0);
    check("rst/mem_write", 32'(mem_write), 32'd0);
    check("rst/mem_address", mem_address, 32'h0);
    reset = 1'b0;
    #1 check("rst/ready_after", 32'(req_ready), 32'd1);

    // Byte loads, signed and unsigned
    mem[3] = 32'h11223344;
    run("ldb_s", 1'b0, 2'b00, 1'b0, 32'h0E, 32'h0, 32'h00000022, 1'b0, 2, 0, 32'h0);
    run("ldb_u", 1'b0, 2'b00, 1'b1, 32'h0E, 32'h0, 32'h00000022, 1'b0, 2, 0, 32'h0);
    mem[3] = 32'h11A23344;
    run("ldb_neg_s", 1'b0, 2'b00, 1'b0, 32'h0E, 32'h0, 32'hFFFFFFA2, 1'b0, 2, 0, 32'h0);
    run("ldb_neg_u", 1'b0, 2'b00, 1'b1, 32'h0E, 32'h0, 32'h000000A2, 1'b0, 2, 0, 32'h0);

    // Sub-word stores via read-modify-write
    mem[3] = 32'h11223344;
    run("stb", 1'b1, 2'b00, 1'b0, 32'h0D, 32'hFFFFFFAB, 32'h0, 1'b0, 3, 2, 32'd3);
    check("stb/mem", mem[3], 32'h1122AB44);
    run("sth", 1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000BEEF, 32'h0, 1'b0, 3, 2, 32'd3);
    check("sth/mem", mem[3], 32'hBEEFAB44);
    run("ldh_s", 1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 0, 32'h0);
    run("ldh_u0", 1'b0, 2'b01, 1'b1, 32'h0C, 32'h0, 32'h0000AB44, 1'b0, 2, 0, 32'h0);

    // Word store and load
    run("stw", 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 32'd8);
    check("stw/mem", mem[8], 32'hDEADBEEF);
    run("ldw", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 32'h0);

    // Last legal word
    run("stw_last", 1'b1, 2'b10, 1'b0, 32'h3FC, 32'h12345678, 32'h0, 1'b0, 2, 1, 32'd255);
    run("ldw_last", 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 32'h12345678, 1'b0, 2, 0, 32'h0);

    // Error cases touch no memory
    mem[0] = 32'hCAFEF00D; mem[1] = 32'h01020304; mem[4] = 32'hA5A5A5A5;
    run("err_ldh_mis", 1'b0, 2'b01, 1'b0, 32'h03, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);
    check("err_ldh_mis/mem", mem[0], 32'hCAFEF00D);
    run("err_stw_mis", 1'b1, 2'b10, 1'b0, 32'h06, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0, 32'h0);
    check("err_stw_mis/mem", mem[1], 32'h01020304);
    run("err_size", 1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0, 32'h0);
    check("err_size/mem", mem[4], 32'hA5A5A5A5);
    run("err_range", 1'b1, 2'b10, 1'b0, 32'h400, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0, 32'h0);
    check("err_range/mem0", mem[0], 32'hCAFEF00D);
    run("err_range_ld", 1'b0, 2'b00, 1'b0, 32'h401, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);

    // Back-to-back with req_valid held high
    idx = 0; nresp = 0; busy = 0;
    for (int cyc = 0; cyc < 40 && nresp < 3; cyc++) begin
      @(negedge clk);
      rdy = req_ready;
      if (!rdy) busy++;
      if (resp_valid) begin
        check($sformatf("b2b/rdata%0d", nresp), resp_rdata, b_exp[nresp]);
        nresp++;
      end
      if (idx < 3) begin
        req_valid = 1'b1; req_write = b_wr[idx]; req_size = b_sz[idx];
        req_unsigned = 1'b0; req_addr = b_addr[idx]; req_wdata = b_wd[idx];
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk);
      if (rdy && req_valid) idx++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    extra = 0;
    repeat (3) begin
      if (resp_valid) extra++;
      @(negedge clk);
    end
    check("b2b/nresp", 32'(nresp), 32'd3);
    check("b2b/accepted", 32'(idx), 32'd3);
    check("b2b/busy_cycles", 32'(busy), 32'd7);
    check("b2b/extra_resp", 32'(extra), 32'd0);
    check("b2b/mem", mem[8], 32'hDEAD55EF);

    // Reset during WRITE of a byte store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rstw/write_state", 32'(mem_write), 32'd1);
    reset = 1'b1;
    #1;
    check("rstw/mem_write_gated", 32'(mem_write), 32'd0);
    check("rstw/ready_in_reset", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("rstw/no_resp", 32'(resp_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("rstw/ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("rstw/ready_idle", 32'(req_ready), 32'd1);
    check("rstw/resp_valid", 32'(resp_valid), 32'd0);
    check("rstw/resp_rdata", resp_rdata, 32'h0);
    check("rstw/resp_error", 32'(resp_error), 32'd0);
    check("rstw/mem_write", 32'(mem_write), 32'd0);
    check("rstw/mem_address", mem_address, 32'h0);
    check("rstw/mem_write_data", mem_write_data, 32'h0);
    check("rstw/mem", mem[8], 32'hDEAD55EF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
